mul_share_ctrl: RTL and testbench

Sequencing controller that shares one iterative 32×32 multiplier between the two issue lanes of the dual-issue execute stage. It replaces the per-lane multipliers: it accepts multiply requests from lane 0 and lane 1, grants the older lane (lane 0) first on collision, and runs the shift-add core. It raises a pipeline stall until every requesting lane holds its 64-bit product, then returns per-lane results for the existing low-word select.

---
 rtl/mul_pkg.sv | 18 +
 rtl/seq_mult_core.sv | 46 ++++
 rtl/mul_share_ctrl.sv | 139 +++++++++++++
 tb/tb_mul_share_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the lane-shared multiplier: controller states and lane index.
// No logic; imported by the controller and the datapath core.
// No flow control of its own.
package mul_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic lane_t;

    localparam lane_t LANE0 = 1'b0;
    localparam lane_t LANE1 = 1'b1;

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned shift-add multiplier datapath: one partial-product add and right shift per step.
// Latency: WIDTH steps after load; acc_nxt exposes the value the current step produces.
// No backpressure: stepping is fully under controller control.
module seq_mult_core
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   sreg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     hi_sum;

    // Upper half absorbs the partial product; the lower half collects bits shifted out.
    always_comb begin
        addend  = sreg[0] ? mcand : '0;
        hi_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_nxt = {hi_sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            sreg  <= '0;
            acc   <= '0;
        end else if (load) begin
            mcand <= a;
            sreg  <= b;
            acc   <= '0;
        end else if (step) begin
            sreg  <= sreg >> 1;
            acc   <= acc_nxt;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one iterative multiplier between two issue lanes; lane 0 wins collisions.
// Latency: WIDTH+1 cycles from request to done per lane; second lane of a collision waits WIDTH more.
// Backpressure: stall held while any requesting lane lacks its result.
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic               sign0,
    input  logic               sign1,
    input  logic [WIDTH-1:0]   srca0,
    input  logic [WIDTH-1:0]   srcb0,
    input  logic [WIDTH-1:0]   srca1,
    input  logic [WIDTH-1:0]   srcb1,
    input  logic               flush,
    output logic [2*WIDTH-1:0] product0,
    output logic [2*WIDTH-1:0] product1,
    output logic               done0,
    output logic               done1,
    output logic               stall,
    output logic               busy
);

    state_t             state, state_nxt;
    lane_t              g;
    lane_t              ld_lane;
    logic               neg;
    logic [CNTW-1:0]    cnt;
    logic               start0, start1, last, ld;
    logic               ld_sign, ld_neg;
    logic [WIDTH-1:0]   a_raw, b_raw, opa, opb;
    logic [2*WIDTH-1:0] res, res_fix;

    assign start0  = req0 & ~done0;
    assign start1  = req1 & ~done1;
    assign stall   = start0 | start1;
    assign busy    = (state == RUN);
    assign last    = busy && (cnt == CNTW'(1));
    assign res_fix = neg ? -res : res;

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        ld_lane   = LANE0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start0 | start1) begin
                        ld        = 1'b1;
                        ld_lane   = start0 ? LANE0 : LANE1;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    // Hand the core straight to the other lane if it is waiting.
                    if (last) begin
                        if ((g == LANE0) ? start1 : start0) begin
                            ld      = 1'b1;
                            ld_lane = ~g;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The core only ever sees magnitudes; the sign is reapplied on writeback.
    always_comb begin
        ld_sign = (ld_lane == LANE1) ? sign1 : sign0;
        a_raw   = (ld_lane == LANE1) ? srca1 : srca0;
        b_raw   = (ld_lane == LANE1) ? srcb1 : srcb0;
        opa     = (ld_sign & a_raw[WIDTH-1]) ? -a_raw : a_raw;
        opb     = (ld_sign & b_raw[WIDTH-1]) ? -b_raw : b_raw;
        ld_neg  = ld_sign & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
    end

    seq_mult_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ld),
        .step    (busy),
        .a       (opa),
        .b       (opb),
        .acc_nxt (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            g        <= LANE0;
            neg      <= 1'b0;
            product0 <= '0;
            product1 <= '0;
            done0    <= 1'b0;
            done1    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt   <= '0;
                done0 <= 1'b0;
                done1 <= 1'b0;
            end else begin
                if (ld) begin
                    g   <= ld_lane;
                    neg <= ld_neg;
                    cnt <= CNTW'(WIDTH);
                end else if (busy) begin
                    cnt <= cnt - CNTW'(1);
                end
                if (!stall) begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
                // A lane that dropped its request still gets its result marked done.
                if (last) begin
                    if (g == LANE0) begin
                        product0 <= res_fix;
                        done0    <= 1'b1;
                    end else begin
                        product1 <= res_fix;
                        done1    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for the lane-shared multiplier controller.
module tb_mul_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, sign0, sign1, flush;
    logic [31:0] srca0, srcb0, srca1, srcb1;
    logic [63:0] product0, product1;
    logic        done0, done1, stall, busy;

    int errors = 0;
    int checks = 0;

    mul_share_ctrl #(.WIDTH(32), .CNTW(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .sign0    (sign0),
        .sign1    (sign1),
        .srca0    (srca0),
        .srcb0    (srcb0),
        .srca1    (srca1),
        .srcb1    (srcb1),
        .flush    (flush),
        .product0 (product0),
        .product1 (product1),
        .done0    (done0),
        .done1    (done1),
        .stall    (stall),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; caller drives then settles.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the request cycle (after settling). Counts cycles until done for the lane.
    task automatic wait_done(input logic lane, output int n, output int stalls, output int busys);
        n = 0; stalls = 0; busys = 0;
        while (((lane == 1'b0) ? done0 : done1) !== 1'b1 && n < 200) begin
            if (stall) stalls++;
            if (busy) busys++;
            @(posedge clk);
            #3;
            n++;
        end
    endtask

    int n, st, bu, n1, st1;
    logic p0_moved;

    initial begin
        rst_n = 1'b0; req0 = 0; req1 = 0; sign0 = 0; sign1 = 0; flush = 0;
        srca0 = 0; srcb0 = 0; srca1 = 0; srcb1 = 0;
        step(); #2;
        chk("rst_product0", product0, 64'd0);
        chk("rst_product1", product1, 64'd0);
        chk("rst_done", {62'd0, done1, done0}, 64'd0);
        chk("rst_busy_stall", {62'd0, busy, stall}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Unsigned 7x6 on lane 0
        req0 = 1; sign0 = 0; srca0 = 32'd7; srcb0 = 32'd6; #2;
        wait_done(1'b0, n, st, bu);
        chk("u_latency", n, 33);
        chk("u_product0", product0, 64'd42);
        chk("u_stall_cycles", st, 33);
        chk("u_busy_cycles", bu, 32);
        chk("u_stall_after", {63'd0, stall}, 64'd0);
        step(); req0 = 0; #2;
        chk("u_done_clear", {63'd0, done0}, 64'd0);

        // Signed -3x5 on lane 1
        step();
        req1 = 1; sign1 = 1; srca1 = 32'hFFFF_FFFD; srcb1 = 32'd5; #2;
        wait_done(1'b1, n, st, bu);
        chk("s_latency", n, 33);
        chk("s_product1", product1, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("s_done0_idle", {63'd0, done0}, 64'd0);
        step(); req1 = 0; #2;

        // Collision: lane 0 unsigned max squared, lane 1 signed min squared
        step();
        req0 = 1; sign0 = 0; srca0 = 32'hFFFF_FFFF; srcb0 = 32'hFFFF_FFFF;
        req1 = 1; sign1 = 1; srca1 = 32'h8000_0000; srcb1 = 32'h8000_0000; #2;
        wait_done(1'b0, n, st, bu);
        chk("c_latency0", n, 33);
        chk("c_product0", product0, 64'hFFFF_FFFE_0000_0001);
        chk("c_done1_pending", {63'd0, done1}, 64'd0);
        n1 = 0; st1 = 0; p0_moved = 0;
        while (done1 !== 1'b1 && n1 < 200) begin
            if (stall) st1++;
            if (product0 !== 64'hFFFF_FFFE_0000_0001 || done0 !== 1'b1) p0_moved = 1;
            @(posedge clk); #3;
            n1++;
        end
        chk("c_latency1", n + n1, 65);
        chk("c_product1", product1, 64'h4000_0000_0000_0000);
        chk("c_stall_cycles", st + st1, 65);
        chk("c_product0_stable", {63'd0, p0_moved}, 64'd0);
        chk("c_stall_after", {63'd0, stall}, 64'd0);
        step(); req0 = 0; req1 = 0; sign1 = 0; #2;

        // Flush 10 cycles into a lane 0 run, request held so it restarts
        step();
        req0 = 1; srca0 = 32'd9; srcb0 = 32'd9; #2;
        repeat (10) step();
        flush = 1; #2;
        chk("f_busy_before", {63'd0, busy}, 64'd1);
        step(); flush = 0; #2;
        chk("f_idle", {63'd0, busy}, 64'd0);
        chk("f_done0", {63'd0, done0}, 64'd0);
        chk("f_product0_kept", product0, 64'hFFFF_FFFE_0000_0001);
        wait_done(1'b0, n, st, bu);
        chk("f_restart_latency", n, 33);
        chk("f_product0", product0, 64'd81);
        step(); req0 = 0; #2;

        // Asynchronous reset 5 cycles into a run
        step();
        req0 = 1; srca0 = 32'd5; srcb0 = 32'd5; #2;
        repeat (5) step();
        #1 rst_n = 1'b0; #1;
        chk("r_product0", product0, 64'd0);
        chk("r_product1", product1, 64'd0);
        chk("r_busy_done", {61'd0, busy, done1, done0}, 64'd0);
        chk("r_stall", {63'd0, stall}, 64'd1);
        step(); rst_n = 1'b1; #2;
        wait_done(1'b0, n, st, bu);
        chk("r_latency", n, 33);
        chk("r_product0_new", product0, 64'd25);
        step(); req0 = 0; #2;

        // Back-to-back on lane 0
        step();
        req0 = 1; srca0 = 32'd2; srcb0 = 32'd3; #2;
        wait_done(1'b0, n, st, bu);
        chk("b_latency1", n, 33);
        chk("b_product0_first", product0, 64'd6);
        step(); srca0 = 32'd4; srcb0 = 32'd5; #2;
        chk("b_no_stale_restart", {61'd0, busy, done0, stall}, 64'd1);
        wait_done(1'b0, n, st, bu);
        chk("b_latency2", n, 33);
        chk("b_product0_second", product0, 64'd20);
        step(); req0 = 0; #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
